// File: rtl/l1_loop_wb_pkg.sv
// rtl/l1_loop_wb_pkg.sv - shared types and constants for the L1 loop Wishbone arbiter
package l1_loop_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_stall_timer.sv
// rtl/wb_stall_timer.sv - stall cycle counter with single-cycle expire pulse
module wb_stall_timer
    import l1_loop_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic expire
);

    localparam logic [15:0] LAST_STALL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // Expire on the stall cycle that would make the count reach TIMEOUT_CYCLES;
    // an ack in that same cycle deasserts stall, so the ack wins.
    assign expire = stall && (count == LAST_STALL);

    // Count consecutive stalled cycles; any ack, idle strobe or loss of grant restarts it.
    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            count <= '0;
        end else if (stall) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/l1_loop_wb_arbiter.sv
// rtl/l1_loop_wb_arbiter.sv - two-master round-robin Wishbone arbiter with bus timeout
module l1_loop_wb_arbiter
    import l1_loop_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 22,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ERRCNT_WIDTH   = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [3:0]              m0_sel_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [3:0]              m1_sel_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [3:0]              s_sel_o,
    input  logic                    s_ack_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,

    output logic [1:0]              grant_o,
    output logic [ERRCNT_WIDTH-1:0] timeout_cnt_o
);

    localparam logic [ERRCNT_WIDTH-1:0] CNT_MAX = {ERRCNT_WIDTH{1'b1}};
    localparam logic [ERRCNT_WIDTH-1:0] CNT_ONE = {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};

    arb_state_t              state;
    logic [1:0]              grant_q;
    logic [1:0]              last_grant;
    logic [1:0]              err_q;
    logic [ERRCNT_WIDTH-1:0] timeout_cnt;

    logic granted;
    logic stall;
    logic expire;

    assign granted = (state == GRANT0) || (state == GRANT1);
    assign stall   = granted && s_stb_o && !s_ack_i;

    wb_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (!stall),
        .stall  (stall),
        .expire (expire)
    );

    // Arbitration FSM: round-robin on ties, grant locked while cyc is held, one-cycle abort.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            grant_q     <= GRANT_NONE;
            last_grant  <= GRANT_M1;
            err_q       <= GRANT_NONE;
            timeout_cnt <= '0;
        end else begin
            err_q <= GRANT_NONE;
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_grant == GRANT_M1)) begin
                        state      <= GRANT0;
                        grant_q    <= GRANT_M0;
                        last_grant <= GRANT_M0;
                    end else if (m1_cyc_i) begin
                        state      <= GRANT1;
                        grant_q    <= GRANT_M1;
                        last_grant <= GRANT_M1;
                    end
                end
                GRANT0, GRANT1: begin
                    if ((state == GRANT0) ? !m0_cyc_i : !m1_cyc_i) begin
                        state   <= IDLE;
                        grant_q <= GRANT_NONE;
                    end else if (expire) begin
                        state   <= ABORT;
                        grant_q <= GRANT_NONE;
                        err_q   <= grant_q;
                        if (timeout_cnt != CNT_MAX) begin
                            timeout_cnt <= timeout_cnt + CNT_ONE;
                        end
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign timeout_cnt_o = timeout_cnt;
    assign m0_err_o      = err_q[0] && !wb_rst_i;
    assign m1_err_o      = err_q[1] && !wb_rst_i;

    // Zero-latency request/response steering for the granted master only.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = 4'b0000;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        case (state)
            GRANT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_cyc_i && m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i && !wb_rst_i;
                m0_dat_o = s_dat_i;
            end
            GRANT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_cyc_i && m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i && !wb_rst_i;
                m1_dat_o = s_dat_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_l1_loop_wb_arbiter.sv
// tb/tb_l1_loop_wb_arbiter.sv - directed self-checking bench for l1_loop_wb_arbiter
module tb_l1_loop_wb_arbiter;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [21:0] m0_adr_i;
    logic [31:0] m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [21:0] m1_adr_i;
    logic [31:0] m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [21:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic [7:0]  timeout_cnt_o;

    int checks = 0;
    int errors = 0;

    l1_loop_wb_arbiter #(
        .ADDR_WIDTH     (22),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16),
        .ERRCNT_WIDTH   (8)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .m0_cyc_i      (m0_cyc_i),
        .m0_stb_i      (m0_stb_i),
        .m0_we_i       (m0_we_i),
        .m0_adr_i      (m0_adr_i),
        .m0_dat_i      (m0_dat_i),
        .m0_sel_i      (m0_sel_i),
        .m0_ack_o      (m0_ack_o),
        .m0_err_o      (m0_err_o),
        .m0_dat_o      (m0_dat_o),
        .m1_cyc_i      (m1_cyc_i),
        .m1_stb_i      (m1_stb_i),
        .m1_we_i       (m1_we_i),
        .m1_adr_i      (m1_adr_i),
        .m1_dat_i      (m1_dat_i),
        .m1_sel_i      (m1_sel_i),
        .m1_ack_o      (m1_ack_o),
        .m1_err_o      (m1_err_o),
        .m1_dat_o      (m1_dat_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_sel_o       (s_sel_o),
        .s_ack_i       (s_ack_i),
        .s_dat_i       (s_dat_i),
        .grant_o       (grant_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic pulse_reset();
        step();
        wb_rst_i = 1;
        idle_inputs();
        step();
        wb_rst_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        wb_rst_i = 1;
        m0_adr_i = 22'h3FFFFF; m0_dat_i = 32'hFFFF_FFFF; m0_sel_i = 4'hF;
        repeat (3) step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errors++; $display("FAIL reset_s_ctrl: got %b expected 000", {s_cyc_o, s_stb_o, s_we_o}); end
        checks++; if ({s_adr_o, s_dat_o, s_sel_o} !== 58'd0) begin errors++; $display("FAIL reset_s_bus: got %h expected 0", {s_adr_o, s_dat_o, s_sel_o}); end
        checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        checks++; if (timeout_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_tcnt: got %0d expected 0", timeout_cnt_o); end
        wb_rst_i = 0;
        idle_inputs();
    endtask

    task automatic test_stb_no_cyc();
        step();
        m0_stb_i = 1; m1_stb_i = 1;
        repeat (2) step();
        checks++; if ({grant_o, s_cyc_o, s_stb_o} !== 4'b0000) begin errors++; $display("FAIL stb_no_cyc: got %b expected 0000", {grant_o, s_cyc_o, s_stb_o}); end
        idle_inputs();
    endtask

    task automatic test_single_read();
        pulse_reset();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 22'h040; m0_sel_i = 4'hF;
        step();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL read_grant: got %b expected 01", grant_o); end
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== 22'h040) begin errors++; $display("FAIL read_s_bus: got cyc=%b adr=%h expected cyc=1 adr=040", s_cyc_o, s_adr_o); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b expected 0", m0_ack_o); end
        end
        step();
        s_ack_i = 1; s_dat_i = 32'h0000_1194;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h0000_1194) begin errors++; $display("FAIL read_ack: got ack=%b dat=%h expected ack=1 dat=00001194", m0_ack_o, m0_dat_o); end
        checks++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'd0) begin errors++; $display("FAIL read_m1_quiet: got ack=%b dat=%h expected 0 0", m1_ack_o, m1_dat_o); end
        step();
        idle_inputs();
        #1;
        checks++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("FAIL read_drop: got cyc=%b grant=%b expected cyc=0 grant=01", s_cyc_o, grant_o); end
        step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL read_idle: got %b expected 00", grant_o); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        step();
        m0_cyc_i = 1; m1_cyc_i = 1;
        step();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", grant_o); end
        m0_cyc_i = 0;
        step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b expected 00", grant_o); end
        step();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", grant_o); end
        m0_cyc_i = 1; m1_cyc_i = 0;
        step();
        m1_cyc_i = 1;
        step();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_tie1: got %b expected 01", grant_o); end
        m0_cyc_i = 0;
        step();
        m0_cyc_i = 1;
        step();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rr_tie2: got %b expected 10", grant_o); end
        m1_cyc_i = 0;
        step();
        m1_cyc_i = 1;
        step();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_tie3: got %b expected 01", grant_o); end
        idle_inputs();
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        step();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF;
        m1_adr_i = 22'h100; m1_dat_i = 32'hA000_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 22'h055;
            m1_adr_i = 22'h100 + 22'(4 * i);
            m1_dat_i = 32'hA000_0000 + 32'(i);
            s_ack_i = 1;
            #1;
            checks++;
            if (grant_o !== 2'b10 || s_adr_o !== 22'h100 + 22'(4 * i) || s_dat_o !== 32'hA000_0000 + 32'(i)
                || s_we_o !== 1'b1 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_beat%0d: got grant=%b adr=%h dat=%h we=%b ack1=%b ack0=%b expected 10 %h %h 1 1 0",
                         i, grant_o, s_adr_o, s_dat_o, s_we_o, m1_ack_o, m0_ack_o, 22'h100 + 22'(4 * i), 32'hA000_0000 + 32'(i));
            end
        end
        step();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        #1;
        checks++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_release: got grant=%b cyc=%b expected 10 0", grant_o, s_cyc_o); end
        step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL b2b_gap: got %b expected 00", grant_o); end
        step();
        checks++; if (grant_o !== 2'b01 || s_adr_o !== 22'h055) begin errors++; $display("FAIL b2b_m0: got grant=%b adr=%h expected 01 055", grant_o, s_adr_o); end
        idle_inputs();
        repeat (2) step();
    endtask

    task automatic test_timeout();
        pulse_reset();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 22'h020;
        repeat (16) step();
        checks++; if (s_cyc_o !== 1'b1 || m0_err_o !== 1'b0 || timeout_cnt_o !== 8'd0) begin errors++; $display("FAIL to_last_stall: got cyc=%b err=%b cnt=%0d expected 1 0 0", s_cyc_o, m0_err_o, timeout_cnt_o); end
        step();
        s_ack_i = 1;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL to_abort_bus: got cyc=%b stb=%b grant=%b expected 0 0 00", s_cyc_o, s_stb_o, grant_o); end
        checks++; if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL to_abort_resp: got err0=%b ack0=%b err1=%b expected 1 0 0", m0_err_o, m0_ack_o, m1_err_o); end
        checks++; if (timeout_cnt_o !== 8'd1) begin errors++; $display("FAIL to_count: got %0d expected 1", timeout_cnt_o); end
        idle_inputs();
        step();
        checks++; if (m0_err_o !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b expected 0", m0_err_o); end
    endtask

    task automatic test_ack_wins();
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (15) step();
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || m0_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ackwin_ack: got ack=%b err=%b dat=%h expected 1 0 deadbeef", m0_ack_o, m0_err_o, m0_dat_o); end
        step();
        s_ack_i = 0;
        #1;
        checks++; if (s_cyc_o !== 1'b1 || m0_err_o !== 1'b0 || timeout_cnt_o !== 8'd1) begin errors++; $display("FAIL ackwin_after: got cyc=%b err=%b cnt=%0d expected 1 0 1", s_cyc_o, m0_err_o, timeout_cnt_o); end
        idle_inputs();
        repeat (2) step();
    endtask

    task automatic test_saturation();
        int bad_pulses = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int k = 0; k < 300; k++) begin
            repeat ((k == 0) ? 17 : 18) step();
            if (m0_err_o !== 1'b1 || s_cyc_o !== 1'b0) bad_pulses++;
            if (k == 199) begin
                checks++; if (timeout_cnt_o !== 8'd201) begin errors++; $display("FAIL sat_mid: got %0d expected 201", timeout_cnt_o); end
            end
        end
        checks++; if (bad_pulses != 0) begin errors++; $display("FAIL sat_period: got %0d missed aborts expected 0", bad_pulses); end
        checks++; if (timeout_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", timeout_cnt_o); end
        idle_inputs();
        repeat (2) step();
    endtask

    task automatic test_reset_mid_grant();
        step();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 22'h0AB;
        step();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rst_pre_grant: got %b expected 10", grant_o); end
        step();
        wb_rst_i = 1; s_ack_i = 1;
        #1;
        checks++; if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL rst_cycle_resp: got ack=%b err=%b expected 0 0", m1_ack_o, m1_err_o); end
        step();
        wb_rst_i = 0; s_ack_i = 0;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || timeout_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_after: got cyc=%b grant=%b cnt=%0d expected 0 00 0", s_cyc_o, grant_o, timeout_cnt_o); end
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        s_ack_i = 1;
        #1;
        checks++; if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got ack1=%b ack0=%b expected 0 0", m1_ack_o, m0_ack_o); end
        idle_inputs();
        step();
    endtask

    initial begin
        wb_rst_i = 1;
        idle_inputs();
        test_reset();
        test_stb_no_cyc();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_ack_wins();
        test_saturation();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
